// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one data-bus transaction per load/store, pipeline
// held via stallreq_mem until ack or timeout, big-endian lanes, result to mem_wb.
module mem_lsu #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_wreg,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic        wb_wreg,
    output logic        stallreq_mem,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        misalign,
    output logic        bus_err
);

    localparam int unsigned CNT_W = 10;
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               bus_req_d, bus_we_d, misalign_d, bus_err_d;
    logic [31:0]        bus_addr_d, bus_wdata_d;
    logic [3:0]         bus_sel_d;

    logic               is_load, is_store, ld_signed, aligned;
    logic [1:0]         size;       // 0 byte, 1 half, 2 word
    logic [3:0]         sel;
    logic [31:0]        st_data, ld_data;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;

    // Operation decode
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        ld_signed = 1'b0;
        size      = 2'd0;
        case (mem_aluop)
            OP_LB:   begin is_load = 1'b1; ld_signed = 1'b1; size = 2'd0; end
            OP_LBU:  begin is_load = 1'b1; size = 2'd0; end
            OP_LH:   begin is_load = 1'b1; ld_signed = 1'b1; size = 2'd1; end
            OP_LHU:  begin is_load = 1'b1; size = 2'd1; end
            OP_LW:   begin is_load = 1'b1; size = 2'd2; end
            OP_SB:   begin is_store = 1'b1; size = 2'd0; end
            OP_SH:   begin is_store = 1'b1; size = 2'd1; end
            OP_SW:   begin is_store = 1'b1; size = 2'd2; end
            default: ;
        endcase
    end

    // Alignment, byte lanes and replicated store data
    always_comb begin
        aligned = 1'b1;
        sel     = 4'b1111;
        st_data = mem_reg2;
        case (size)
            2'd0: begin
                sel     = 4'b1000 >> mem_mem_addr[1:0];
                st_data = {4{mem_reg2[7:0]}};
            end
            2'd1: begin
                aligned = ~mem_mem_addr[0];
                sel     = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
                st_data = {2{mem_reg2[15:0]}};
            end
            default: aligned = (mem_mem_addr[1:0] == 2'b00);
        endcase
    end

    // Load lane extraction and extension from the captured read word
    always_comb begin
        case (mem_mem_addr[1:0])
            2'd0:    ld_byte = rdata_q[31:24];
            2'd1:    ld_byte = rdata_q[23:16];
            2'd2:    ld_byte = rdata_q[15:8];
            default: ld_byte = rdata_q[7:0];
        endcase
        ld_half = mem_mem_addr[1] ? rdata_q[15:0] : rdata_q[31:16];
        case (size)
            2'd0:    ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            2'd1:    ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
            default: ld_data = rdata_q;
        endcase
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        bus_req_d    = bus_req;
        bus_we_d     = bus_we;
        bus_addr_d   = bus_addr;
        bus_sel_d    = bus_sel;
        bus_wdata_d  = bus_wdata;
        misalign_d   = 1'b0;
        bus_err_d    = 1'b0;
        stallreq_mem = 1'b0;
        wb_waddr     = 5'd0;
        wb_wdata     = 32'd0;
        wb_wreg      = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_load || is_store) begin
                    if (aligned) begin
                        stallreq_mem = 1'b1;
                        state_d      = BUSY;
                        cnt_d        = '0;
                        bus_req_d    = 1'b1;
                        bus_we_d     = is_store;
                        bus_addr_d   = {mem_mem_addr[31:2], 2'b00};
                        bus_sel_d    = sel;
                        bus_wdata_d  = st_data;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end else begin
                    wb_waddr = mem_waddr;
                    wb_wdata = mem_wdata;
                    wb_wreg  = mem_wreg;
                end
            end
            BUSY: begin
                stallreq_mem = 1'b1;
                if (bus_ack) begin
                    rdata_d   = bus_rdata;
                    bus_req_d = 1'b0;
                    state_d   = DONE;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                if (is_load) begin
                    wb_waddr = mem_waddr;
                    wb_wdata = ld_data;
                    wb_wreg  = mem_wreg & ~bus_err;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!rst) begin
            wb_waddr = 5'd0;
            wb_wdata = 32'd0;
            wb_wreg  = 1'b0;
        end
    end

    // State and bus registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rdata_q   <= 32'd0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_sel   <= 4'd0;
            bus_wdata <= 32'd0;
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            bus_req   <= bus_req_d;
            bus_we    <= bus_we_d;
            bus_addr  <= bus_addr_d;
            bus_sel   <= bus_sel_d;
            bus_wdata <= bus_wdata_d;
            misalign  <= misalign_d;
            bus_err   <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed testbench for mem_lsu with ACK_TIMEOUT=4; inputs change 1 ns after
// the rising edge and outputs are sampled a further 1 ns later.
module tb_mem_lsu;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ADD = 8'b0010_0000;
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    logic        clk, rst;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr, mem_reg2, mem_wdata, bus_rdata;
    logic [4:0]  mem_waddr;
    logic        mem_wreg, bus_ack;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata, bus_addr, bus_wdata;
    logic        wb_wreg, stallreq_mem, bus_req, bus_we, misalign, bus_err;
    logic [3:0]  bus_sel;

    int tests_run = 0;
    int tests_failed = 0;
    int req_pulses = 0;
    logic req_prev = 1'b0;

    mem_lsu #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
        .mem_reg2(mem_reg2), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wreg(mem_wreg), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .wb_wreg(wb_wreg), .stallreq_mem(stallreq_mem), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .misalign(misalign), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges of bus_req as seen at each clock
    always @(posedge clk) begin
        if (bus_req && !req_prev) req_pulses++;
        req_prev <= bus_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] reg2, input logic [4:0] waddr,
                          input logic [31:0] wdata, input logic wreg);
        mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2;
        mem_waddr = waddr; mem_wdata = wdata; mem_wreg = wreg;
    endtask

    task automatic test_reset();
        rst = 1'b0; bus_ack = 1'b0; bus_rdata = 32'd0;
        set_op(OP_ADD, 32'h0, 32'h0, 5'd3, 32'hDEADBEEF, 1'b1);
        tick(); tick();
        tests_run++; if (bus_req !== 1'b0) begin tests_failed++; $display("FAIL reset_bus_req got %h want 0", bus_req); end
        tests_run++; if ({bus_we, bus_sel, bus_addr, bus_wdata} !== 69'd0) begin tests_failed++; $display("FAIL reset_bus_regs got %h/%h/%h/%h want 0", bus_we, bus_sel, bus_addr, bus_wdata); end
        tests_run++; if ({misalign, bus_err} !== 2'b00) begin tests_failed++; $display("FAIL reset_pulses got %b want 00", {misalign, bus_err}); end
        tests_run++; if ({wb_wreg, wb_waddr, wb_wdata} !== 38'd0) begin tests_failed++; $display("FAIL reset_wb_forced got %b/%h/%h want 0", wb_wreg, wb_waddr, wb_wdata); end
        rst = 1'b1;
        set_op(OP_NOP, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        tick();
    endtask

    task automatic test_passthrough();
        set_op(OP_ADD, 32'h0, 32'h0, 5'd5, 32'h12345678, 1'b1);
        #1;
        tests_run++; if ({wb_wreg, wb_waddr, wb_wdata} !== {1'b1, 5'd5, 32'h12345678}) begin tests_failed++; $display("FAIL passthru_wb got %b/%h/%h want 1/05/12345678", wb_wreg, wb_waddr, wb_wdata); end
        tests_run++; if (stallreq_mem !== 1'b0) begin tests_failed++; $display("FAIL passthru_stall got %b want 0", stallreq_mem); end
        tick();
        tests_run++; if (bus_req !== 1'b0) begin tests_failed++; $display("FAIL passthru_bus_req got %b want 0", bus_req); end
        set_op(OP_NOP, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        tick();
    endtask

    task automatic test_byte_load(input logic [7:0] op, input logic [31:0] expect_data);
        int stalls;
        stalls = 0;
        set_op(op, 32'h1003, 32'h0, 5'd7, 32'h0, 1'b1);
        #1;
        if (stallreq_mem) stalls++;
        tests_run++; if (wb_wreg !== 1'b0) begin tests_failed++; $display("FAIL ld_idle_wreg op=%h got %b want 0", op, wb_wreg); end
        tick();
        if (stallreq_mem) stalls++;
        tests_run++; if ({bus_req, bus_we, bus_addr, bus_sel} !== {1'b1, 1'b0, 32'h1000, 4'b0001}) begin tests_failed++; $display("FAIL ld_bus op=%h got req=%b we=%b addr=%h sel=%b want 1/0/00001000/0001", op, bus_req, bus_we, bus_addr, bus_sel); end
        bus_ack = 1'b1; bus_rdata = 32'h000000F0;
        tick();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        if (stallreq_mem) stalls++;
        tests_run++; if (stalls !== 2) begin tests_failed++; $display("FAIL ld_stall_cycles op=%h got %0d want 2", op, stalls); end
        tests_run++; if ({wb_wreg, wb_waddr, wb_wdata} !== {1'b1, 5'd7, expect_data}) begin tests_failed++; $display("FAIL ld_done_wb op=%h got %b/%h/%h want 1/07/%h", op, wb_wreg, wb_waddr, wb_wdata, expect_data); end
        tests_run++; if (bus_req !== 1'b0) begin tests_failed++; $display("FAIL ld_done_req op=%h got %b want 0", op, bus_req); end
        set_op(OP_NOP, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        tick();
    endtask

    task automatic test_store_half();
        int req_cycles;
        req_cycles = 0;
        set_op(OP_SH, 32'h2002, 32'hAAAABEEF, 5'd0, 32'h0, 1'b0);
        tick();
        tests_run++; if ({bus_we, bus_sel, bus_wdata, bus_addr} !== {1'b1, 4'b0011, 32'hBEEFBEEF, 32'h2000}) begin tests_failed++; $display("FAIL sh_bus got we=%b sel=%b wdata=%h addr=%h want 1/0011/beefbeef/00002000", bus_we, bus_sel, bus_wdata, bus_addr); end
        for (int k = 1; k <= 6 && bus_req; k++) begin
            req_cycles++;
            if (k == 4) bus_ack = 1'b1;
            tick();
            bus_ack = 1'b0;
        end
        tests_run++; if (req_cycles !== 4) begin tests_failed++; $display("FAIL sh_req_cycles got %0d want 4", req_cycles); end
        tests_run++; if ({wb_wreg, stallreq_mem, bus_err} !== 3'b000) begin tests_failed++; $display("FAIL sh_done got wreg=%b stall=%b err=%b want 000", wb_wreg, stallreq_mem, bus_err); end
        set_op(OP_NOP, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        tick();
    endtask

    task automatic test_misalign();
        set_op(OP_LW, 32'h3001, 32'h0, 5'd4, 32'h0, 1'b1);
        #1;
        tests_run++; if ({stallreq_mem, wb_wreg} !== 2'b00) begin tests_failed++; $display("FAIL mis_comb got stall=%b wreg=%b want 00", stallreq_mem, wb_wreg); end
        tick();
        set_op(OP_NOP, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        tests_run++; if ({misalign, bus_req} !== 2'b10) begin tests_failed++; $display("FAIL mis_pulse got mis=%b req=%b want 10", misalign, bus_req); end
        tick();
        tests_run++; if ({misalign, bus_req} !== 2'b00) begin tests_failed++; $display("FAIL mis_end got mis=%b req=%b want 00", misalign, bus_req); end
    endtask

    task automatic test_timeout();
        int busy;
        busy = 0;
        set_op(OP_LW, 32'h4000, 32'h0, 5'd3, 32'h0, 1'b1);
        tick();
        while (bus_req && busy < 10) begin
            busy++;
            tick();
        end
        tests_run++; if (busy !== 4) begin tests_failed++; $display("FAIL to_busy_cycles got %0d want 4", busy); end
        tests_run++; if ({bus_err, wb_wreg, stallreq_mem} !== 3'b100) begin tests_failed++; $display("FAIL to_done got err=%b wreg=%b stall=%b want 100", bus_err, wb_wreg, stallreq_mem); end
        set_op(OP_ADD, 32'h0, 32'h0, 5'd2, 32'h55, 1'b1);
        tick();
        tests_run++; if ({bus_err, stallreq_mem, wb_wreg} !== 3'b001) begin tests_failed++; $display("FAIL to_idle got err=%b stall=%b wreg=%b want 001", bus_err, stallreq_mem, wb_wreg); end
        // Rerun and reset in the middle of BUSY
        set_op(OP_LW, 32'h4000, 32'h0, 5'd3, 32'h0, 1'b1);
        tick(); tick();
        rst = 1'b0;
        #1;
        tests_run++; if ({bus_req, wb_wreg} !== 2'b00) begin tests_failed++; $display("FAIL to_async_rst got req=%b wreg=%b want 00", bus_req, wb_wreg); end
        set_op(OP_ADD, 32'h0, 32'h0, 5'd2, 32'h55, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        tests_run++; if ({stallreq_mem, wb_wreg, bus_req} !== 3'b010) begin tests_failed++; $display("FAIL to_rst_idle got stall=%b wreg=%b req=%b want 010", stallreq_mem, wb_wreg, bus_req); end
        set_op(OP_NOP, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        tick();
    endtask

    task automatic test_back_to_back();
        req_pulses = 0;
        set_op(OP_SW, 32'h5000, 32'hCAFEF00D, 5'd0, 32'h0, 1'b0);
        #1;
        tests_run++; if (stallreq_mem !== 1'b1) begin tests_failed++; $display("FAIL b2b_sw_idle_stall got %b want 1", stallreq_mem); end
        tick();
        tests_run++; if ({bus_we, bus_sel, bus_wdata} !== {1'b1, 4'b1111, 32'hCAFEF00D}) begin tests_failed++; $display("FAIL b2b_sw_bus got we=%b sel=%b wdata=%h want 1/1111/cafef00d", bus_we, bus_sel, bus_wdata); end
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        tests_run++; if ({stallreq_mem, wb_wreg} !== 2'b00) begin tests_failed++; $display("FAIL b2b_sw_done got stall=%b wreg=%b want 00", stallreq_mem, wb_wreg); end
        set_op(OP_LW, 32'h6004, 32'h0, 5'd9, 32'h0, 1'b1);
        tick();
        tests_run++; if ({stallreq_mem, bus_req} !== 2'b10) begin tests_failed++; $display("FAIL b2b_lw_idle got stall=%b req=%b want 10", stallreq_mem, bus_req); end
        tick();
        tests_run++; if ({bus_req, bus_we, bus_addr} !== {1'b1, 1'b0, 32'h6004}) begin tests_failed++; $display("FAIL b2b_lw_bus got req=%b we=%b addr=%h want 1/0/00006004", bus_req, bus_we, bus_addr); end
        bus_ack = 1'b1; bus_rdata = 32'h89ABCDEF;
        tick();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        tests_run++; if ({wb_wreg, wb_waddr, wb_wdata} !== {1'b1, 5'd9, 32'h89ABCDEF}) begin tests_failed++; $display("FAIL b2b_lw_done got %b/%h/%h want 1/09/89abcdef", wb_wreg, wb_waddr, wb_wdata); end
        set_op(OP_NOP, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        tick(); tick();
        tests_run++; if (req_pulses !== 2) begin tests_failed++; $display("FAIL b2b_req_pulses got %0d want 2", req_pulses); end
    endtask

    task automatic test_stray_ack();
        set_op(OP_ADD, 32'h0, 32'h0, 5'd1, 32'h77, 1'b1);
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        tick(); tick();
        bus_ack = 1'b0;
        tests_run++; if ({bus_req, stallreq_mem, wb_wreg, wb_wdata} !== {3'b001, 32'h77}) begin tests_failed++; $display("FAIL stray_ack got req=%b stall=%b wreg=%b wdata=%h want 0/0/1/00000077", bus_req, stallreq_mem, wb_wreg, wb_wdata); end
        set_op(OP_NOP, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        tick();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_byte_load(OP_LB, 32'hFFFFFFF0);
        test_byte_load(OP_LBU, 32'h000000F0);
        test_store_half();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_stray_ack();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired after %0d tests", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
